// File: rtl/not_not_pkg.sv
// rtl/not_not_pkg.sv - shared state encoding and colour indices for the Not-Not game
package not_not_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    NEW_ROUND,
    DRAW,
    WAIT_INPUT,
    LOSE
  } state_e;

  // Colour indices as shown by the hex_decoder display
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

endpackage

// File: rtl/not_not_round_timer.sv
// rtl/not_not_round_timer.sv - answer-window register and per-round down-counter
module not_not_round_timer #(
  parameter int TIMER_W      = 27,
  parameter int TIMEOUT_INIT = 100_000_000,
  parameter int TIMEOUT_STEP = 2_500_000,
  parameter int TIMEOUT_MIN  = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  input  logic win_init_i,
  input  logic win_step_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] INIT_W = TIMER_W'(TIMEOUT_INIT);
  localparam logic [TIMER_W-1:0] STEP_W = TIMER_W'(TIMEOUT_STEP);
  localparam logic [TIMER_W-1:0] MIN_W  = TIMER_W'(TIMEOUT_MIN);
  localparam logic [TIMER_W-1:0] ONE_W  = TIMER_W'(1);
  // One extra bit so the floor+step threshold itself cannot wrap
  localparam logic [TIMER_W:0]   SHRINK_LIMIT = {1'b0, MIN_W} + {1'b0, STEP_W};

  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] window_q, window_d;

  always_comb begin
    count_d  = count_q;
    window_d = window_q;
    if (load_i) begin
      count_d = window_q;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - ONE_W;
    end
    if (win_init_i) begin
      window_d = INIT_W;
    end else if (win_step_i) begin
      if ({1'b0, window_q} >= SHRINK_LIMIT) window_d = window_q - STEP_W;
      else                                  window_d = MIN_W;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      window_q <= INIT_W;
    end else begin
      count_q  <= count_d;
      window_q <= window_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/not_not_game_ctrl.sv
// rtl/not_not_game_ctrl.sv - round sequencer: clear, advance prompt, draw, await key, score
module not_not_game_ctrl
  import not_not_pkg::*;
#(
  parameter int TIMEOUT_INIT = 100_000_000,
  parameter int TIMEOUT_STEP = 2_500_000,
  parameter int TIMEOUT_MIN  = 25_000_000,
  parameter int TIMER_W      = 27,
  parameter int SCORE_W      = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               key_press_i,
  input  logic [1:0]         key_sel_i,
  input  logic [3:0]         expected_i,
  input  logic               done_draw_i,
  input  logic               done_draw_black_i,
  output logic               lfsr_enable_o,
  output logic               draw_enable_o,
  output logic               black_o,
  output logic               show_start_o,
  output logic               lose_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               round_active_o
);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         exp_q, exp_d;
  logic               timer_load, timer_run, win_init, win_step, expired;
  logic               correct;

  not_not_round_timer #(
    .TIMER_W      (TIMER_W),
    .TIMEOUT_INIT (TIMEOUT_INIT),
    .TIMEOUT_STEP (TIMEOUT_STEP),
    .TIMEOUT_MIN  (TIMEOUT_MIN)
  ) u_timer (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (timer_load),
    .run_i      (timer_run),
    .win_init_i (win_init),
    .win_step_i (win_step),
    .expired_o  (expired)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    exp_d      = exp_q;
    timer_load = 1'b0;
    win_init   = 1'b0;
    win_step   = 1'b0;
    correct    = 1'b0;
    timer_run  = (state_q == WAIT_INPUT);
    unique case (state_q)
      IDLE, LOSE: begin
        if (start_i) begin
          state_d  = CLEAR;
          score_d  = '0;
          win_init = 1'b1;
        end
      end
      CLEAR:     if (done_draw_black_i) state_d = NEW_ROUND;
      NEW_ROUND: state_d = DRAW;
      DRAW: begin
        if (done_draw_i) begin
          exp_d      = expected_i;
          timer_load = 1'b1;
          state_d    = WAIT_INPUT;
        end
      end
      WAIT_INPUT: begin
        // A key press outranks a simultaneous timeout
        if (key_press_i) begin
          correct = exp_q[key_sel_i];
          if (!correct) state_d = LOSE;
        end else if (expired) begin
          correct = (exp_q == 4'b0000);
          if (!correct) state_d = LOSE;
        end
        if (correct) begin
          state_d  = CLEAR;
          win_step = 1'b1;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      score_q <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      exp_q   <= exp_d;
    end
  end

  assign show_start_o   = (state_q == IDLE);
  assign black_o        = (state_q == CLEAR);
  assign lfsr_enable_o  = (state_q == NEW_ROUND);
  assign draw_enable_o  = (state_q == DRAW);
  assign round_active_o = (state_q == WAIT_INPUT);
  assign lose_o         = (state_q == LOSE);
  assign score_o        = score_q;

endmodule

// File: tb/tb_not_not_game_ctrl.sv
// tb/tb_not_not_game_ctrl.sv - self-checking bench for not_not_game_ctrl
module tb_not_not_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_reset, a_start, a_key_press, a_done_draw, a_done_draw_black;
  logic [1:0] a_key_sel;
  logic [3:0] a_expected;
  logic a_lfsr_enable, a_draw_enable, a_black, a_show_start, a_lose, a_round_active;
  logic [7:0] a_score;

  logic b_reset, b_start, b_key_press, b_done_draw, b_done_draw_black;
  logic [1:0] b_key_sel;
  logic [3:0] b_expected;
  logic b_lfsr_enable, b_draw_enable, b_black, b_show_start, b_lose, b_round_active;
  logic [7:0] b_score;

  not_not_game_ctrl dut_a (
    .clock_i(clk), .reset_i(a_reset), .start_i(a_start), .key_press_i(a_key_press),
    .key_sel_i(a_key_sel), .expected_i(a_expected), .done_draw_i(a_done_draw),
    .done_draw_black_i(a_done_draw_black), .lfsr_enable_o(a_lfsr_enable),
    .draw_enable_o(a_draw_enable), .black_o(a_black), .show_start_o(a_show_start),
    .lose_o(a_lose), .score_o(a_score), .round_active_o(a_round_active)
  );

  not_not_game_ctrl #(.TIMEOUT_INIT(10), .TIMEOUT_STEP(2), .TIMEOUT_MIN(3)) dut_b (
    .clock_i(clk), .reset_i(b_reset), .start_i(b_start), .key_press_i(b_key_press),
    .key_sel_i(b_key_sel), .expected_i(b_expected), .done_draw_i(b_done_draw),
    .done_draw_black_i(b_done_draw_black), .lfsr_enable_o(b_lfsr_enable),
    .draw_enable_o(b_draw_enable), .black_o(b_black), .show_start_o(b_show_start),
    .lose_o(b_lose), .score_o(b_score), .round_active_o(b_round_active)
  );

  // {show_start, black, lfsr_enable, draw_enable, round_active, lose}
  localparam logic [5:0] F_IDLE = 6'b100000;
  localparam logic [5:0] F_CLR  = 6'b010000;
  localparam logic [5:0] F_NEW  = 6'b001000;
  localparam logic [5:0] F_DRW  = 6'b000100;
  localparam logic [5:0] F_WAIT = 6'b000010;
  localparam logic [5:0] F_LOSE = 6'b000001;

  typedef struct packed {
    logic       st;
    logic       kp;
    logic [1:0] ks;
    logic [3:0] ex;
    logic       dd;
    logic       ddb;
    logic [5:0] flags;
    logic [7:0] score;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic st, input logic kp, input logic [1:0] ks,
                              input logic [3:0] ex, input logic dd, input logic ddb,
                              input logic [5:0] flags, input logic [7:0] score);
    vec_t v;
    v.st = st; v.kp = kp; v.ks = ks; v.ex = ex; v.dd = dd; v.ddb = ddb;
    v.flags = flags; v.score = score;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] a_out();
    return {a_show_start, a_black, a_lfsr_enable, a_draw_enable, a_round_active, a_lose, a_score};
  endfunction

  // From CLEAR to the first WAIT_INPUT cycle of dut_b
  task automatic b_to_wait(input logic [3:0] e);
    b_done_draw_black = 1'b1; step(); b_done_draw_black = 1'b0;
    step();
    b_expected = e; b_done_draw = 1'b1; step(); b_done_draw = 1'b0;
  endtask

  task automatic b_round_key(input logic [3:0] e, input logic [1:0] k);
    b_to_wait(e);
    b_key_press = 1'b1; b_key_sel = k; step(); b_key_press = 1'b0;
  endtask

  initial begin
    int cycles;
    logic mono;
    logic [26:0] prev_win;
    logic [26:0] b_wins[5];

    a_reset = 1'b1; a_start = 0; a_key_press = 0; a_key_sel = 0; a_expected = 0;
    a_done_draw = 0; a_done_draw_black = 0;
    b_reset = 1'b1; b_start = 0; b_key_press = 0; b_key_sel = 0; b_expected = 0;
    b_done_draw = 0; b_done_draw_black = 0;

    vecs[0]  = mk(0, 0, 0, 4'b0100, 0, 0, F_IDLE, 0);
    vecs[1]  = mk(0, 1, 2, 4'b0100, 0, 0, F_IDLE, 0);
    vecs[2]  = mk(1, 0, 0, 4'b0100, 0, 0, F_CLR,  0);
    vecs[3]  = mk(1, 1, 2, 4'b0100, 1, 0, F_CLR,  0);
    vecs[4]  = mk(0, 0, 0, 4'b0100, 0, 1, F_NEW,  0);
    vecs[5]  = mk(0, 0, 0, 4'b0100, 0, 0, F_DRW,  0);
    vecs[6]  = mk(0, 0, 0, 4'b0100, 0, 0, F_DRW,  0);
    vecs[7]  = mk(0, 0, 0, 4'b0100, 1, 0, F_WAIT, 0);
    vecs[8]  = mk(1, 0, 0, 4'b0001, 0, 1, F_WAIT, 0);
    vecs[9]  = mk(0, 1, 2, 4'b0001, 0, 0, F_CLR,  1);
    vecs[10] = mk(0, 0, 0, 4'b0100, 0, 1, F_NEW,  1);
    vecs[11] = mk(0, 0, 0, 4'b0100, 0, 0, F_DRW,  1);
    vecs[12] = mk(0, 0, 0, 4'b0100, 1, 0, F_WAIT, 1);
    vecs[13] = mk(0, 1, 0, 4'b0100, 0, 0, F_LOSE, 1);
    vecs[14] = mk(0, 1, 2, 4'b0100, 1, 1, F_LOSE, 1);
    vecs[15] = mk(1, 0, 0, 4'b0100, 0, 0, F_CLR,  0);

    b_wins[0] = 27'd6; b_wins[1] = 27'd4; b_wins[2] = 27'd3;
    b_wins[3] = 27'd3; b_wins[4] = 27'd3;

    #12;
    chk("reset_a_outputs", {18'd0, a_out()}, {18'd0, F_IDLE, 8'd0});
    chk("reset_b_outputs", {26'd0, b_show_start, b_black, b_lfsr_enable, b_draw_enable,
                            b_round_active, b_lose}, {26'd0, F_IDLE});
    #1;
    a_reset = 1'b0; b_reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      a_start = vecs[i].st; a_key_press = vecs[i].kp; a_key_sel = vecs[i].ks;
      a_expected = vecs[i].ex; a_done_draw = vecs[i].dd; a_done_draw_black = vecs[i].ddb;
      step();
      chk($sformatf("vec%0d", i), {18'd0, a_out()}, {18'd0, vecs[i].flags, vecs[i].score});
      if (i == 9) chk("window_after_first_win", 32'(dut_a.u_timer.window_q), 32'd97_500_000);
    end
    a_start = 0; a_key_press = 0; a_done_draw = 0; a_done_draw_black = 0;

    mono = 1'b1;
    prev_win = 27'd100_000_000;
    for (int r = 0; r < 40; r++) begin
      a_done_draw_black = 1'b1; step(); a_done_draw_black = 1'b0;
      step();
      a_expected = 4'b0100; a_done_draw = 1'b1; step(); a_done_draw = 1'b0;
      a_key_press = 1'b1; a_key_sel = 2'd2; step(); a_key_press = 1'b0;
      if (dut_a.u_timer.window_q > prev_win || dut_a.u_timer.window_q < 27'd25_000_000)
        mono = 1'b0;
      prev_win = dut_a.u_timer.window_q;
    end
    chk("a_score_40", 32'(a_score), 32'd40);
    chk("a_window_floor", 32'(dut_a.u_timer.window_q), 32'd25_000_000);
    chk("a_window_no_wrap", 32'(mono), 32'd1);

    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_start_black", 32'(b_black), 32'd1);
    b_to_wait(4'b0000);
    cycles = 0;
    while (b_round_active && cycles < 30) begin step(); cycles++; end
    chk("b_empty_timeout_len", 32'(cycles >= 10 && cycles <= 11), 32'd1);
    chk("b_empty_timeout_win", {30'd0, b_black, b_lose}, 32'b10);
    chk("b_empty_timeout_score", 32'(b_score), 32'd1);

    b_to_wait(4'b1111);
    cycles = 0;
    while (b_round_active && cycles < 30) begin step(); cycles++; end
    chk("b_full_timeout_lose", 32'(b_lose), 32'd1);
    chk("b_full_timeout_score", 32'(b_score), 32'd1);

    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_restart_score", 32'(b_score), 32'd0);
    b_to_wait(4'b0001);
    b_expected = 4'b1110;
    cycles = 0;
    while (dut_b.u_timer.count_q != 0 && cycles < 30) begin step(); cycles++; end
    chk("b_reach_zero_in_wait", 32'(b_round_active), 32'd1);
    b_key_press = 1'b1; b_key_sel = 2'd0; step(); b_key_press = 1'b0;
    chk("b_press_at_zero", {29'd0, b_black, b_lose, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("b_press_at_zero_score", 32'(b_score), 32'd1);

    for (int r = 0; r < 5; r++) begin
      b_round_key(4'b0001, 2'd0);
      chk($sformatf("b_window_r%0d", r), 32'(dut_b.u_timer.window_q), 32'(b_wins[r]));
    end
    chk("b_score_6", 32'(b_score), 32'd6);

    for (int r = 0; r < 249; r++) b_round_key(4'b1000, 2'd3);
    chk("b_score_255", 32'(b_score), 32'd255);
    b_round_key(4'b0010, 2'd1);
    chk("b_score_saturate", {30'd0, b_black, 1'b0}, 32'b10);
    chk("b_score_saturate_val", 32'(b_score), 32'd255);

    b_done_draw_black = 1'b1; step(); b_done_draw_black = 1'b0;
    step();
    chk("b_in_draw", 32'(b_draw_enable), 32'd1);
    #3 b_reset = 1'b1;
    #1;
    chk("b_async_reset", {26'd0, b_show_start, b_black, b_lfsr_enable, b_draw_enable,
                          b_round_active, b_lose}, {26'd0, F_IDLE});
    chk("b_async_reset_score", 32'(b_score), 32'd0);
    #1 b_reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/not_not_game_ctrl.md
Name: not_not_game_ctrl

Overview:
Round sequencer for the Not-Not game. Sits between the four prompt LFSRs, the expected-answer logic, the text_display drawer and the player keys. Each round it clears the screen, advances the prompt, draws it and waits for one key press against a shrinking deadline. It then scores the round or ends the game.

Parameters:
TIMEOUT_INIT, 100_000_000, first-round answer window in clock cycles (2 s at 50 MHz)
TIMEOUT_STEP, 2_500_000, window reduction applied after each correct round
TIMEOUT_MIN, 25_000_000, floor for the answer window
TIMER_W, 27, width of the timer and window registers
SCORE_W, 8, width of the score counter

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a game (accepted in IDLE and LOSE only)
key_press  in  1  one-cycle pulse: player pressed a colour key
key_sel  in  2  index of the pressed colour (0..3), valid with key_press
expected  in  4  one-hot/multi-hot set of correct colours (not_not_output), combinational from the LFSRs
done_draw  in  1  text_display finished drawing the prompt
done_draw_black  in  1  text_display finished the black clear
lfsr_enable  out  1  one-cycle pulse: advance all prompt LFSRs
draw_enable  out  1  held high while the prompt is drawn
black  out  1  held high while the screen is cleared
show_start  out  1  high in IDLE (start screen)
lose  out  1  high in LOSE
score  out  SCORE_W  correct rounds in the current game
round_active  out  1  high in WAIT_INPUT

Behaviour:
- Reset (async, active-high) sets state to IDLE, score=0, timer=0, window=TIMEOUT_INIT, exp_q=0. Resulting outputs: show_start=1; all other outputs 0.
- All outputs are Moore, decoded from the registered state. score is a register.
- IDLE: on start, go to CLEAR, clear score to 0 and set window to TIMEOUT_INIT.
- CLEAR: black=1. On done_draw_black, go to NEW_ROUND.
- NEW_ROUND: lfsr_enable=1 for exactly one cycle, then DRAW unconditionally.
- DRAW: draw_enable=1 until done_draw.
  - On done_draw, capture expected into exp_q, load timer=window, go to WAIT_INPUT.
  - expected is sampled only here. Later changes to expected are ignored.
- WAIT_INPUT: round_active=1. The timer decrements by 1 per cycle.
  - key_press with exp_q[key_sel]=1 is correct:
    - score increments, saturating at 2^SCORE_W-1;
    - window = max(window-TIMEOUT_STEP, TIMEOUT_MIN);
    - go to CLEAR.
  - key_press with exp_q[key_sel]=0 goes to LOSE.
  - Timer reaches 0 with no press:
    - if exp_q==4'b0000 (no correct colour, e.g. an AND of two different colours), the round is correct; same updates as above, go to CLEAR;
    - otherwise go to LOSE.
  - If key_press and timer==0 occur in the same cycle, the key press is evaluated and the timeout is ignored.
- LOSE: lose=1, score is held. On start, go to CLEAR with score=0 and window=TIMEOUT_INIT.
- Signals ignored outside their state:
  - key_press and key_sel outside WAIT_INPUT;
  - start outside IDLE/LOSE;
  - done_draw outside DRAW;
  - done_draw_black outside CLEAR.
- The window subtraction must not underflow: compare before subtracting, and clamp to TIMEOUT_MIN.
- Reset asserted mid-round returns to IDLE immediately. lfsr_enable, draw_enable and black drop asynchronously.
- Latency:
  - start to black: 1 cycle;
  - done_draw_black to lfsr_enable: 1 cycle;
  - lfsr_enable to draw_enable: 1 cycle;
  - done_draw to round_active: 1 cycle.

Decomposition:
- Shared package (not_not_pkg):
  - state enumeration IDLE, CLEAR, NEW_ROUND, DRAW, WAIT_INPUT, LOSE;
  - colour index constants RED=0..3, matching the hex_decoder display.
- One sub-module, not_not_round_timer: loadable down-counter with window register, step/floor clamp and expired flag.
- FSM, score and answer check stay in the top controller.

Test Plan:
- Reset → show_start=1, score=0, other outputs 0. Pulse start → black=1 the next cycle. done_draw_black → exactly one lfsr_enable cycle, then draw_enable=1.
- In WAIT_INPUT with expected=4'b0100: key_press with key_sel=2 → score=1, state CLEAR, window=TIMEOUT_INIT-TIMEOUT_STEP. key_sel=0 instead → lose=1, score unchanged.
- Set TIMEOUT_INIT=10 and expected=4'b0000, no press → after 10 cycles score increments and black=1. Same run with expected=4'b1111 → lose=1.
- key_press (correct key) in the same cycle timer hits 0 → score increments, no LOSE. expected changes during WAIT_INPUT → the decision uses the captured exp_q.
- Run 40 correct rounds with the defaults → window clamps at 25_000_000, never wraps. Force score=255 then a correct round → score stays 255.
- Assert reset during DRAW → draw_enable falls without waiting for a clock edge, state IDLE. key_press, done_draw and start during CLEAR cause no state change.
